// File: rtl/red_pkg.sv
// Shared constants and elaboration helpers for the pipelined RED lane-sum datapath.
package red_pkg;

  typedef enum logic {
    RED_UNSIGNED = 1'b0,
    RED_SIGNED   = 1'b1
  } red_mode_e;

  function automatic int unsigned red_clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned p = 1; p < n; p = p << 1) r++;
    return r;
  endfunction

  function automatic int unsigned red_levels(input int unsigned data_w, input int unsigned lane_w);
    return red_clog2(2 * data_w / lane_w);
  endfunction

  function automatic int unsigned red_sum_w(input int unsigned data_w, input int unsigned lane_w);
    return lane_w + red_levels(data_w, lane_w);
  endfunction

  // Entry count remaining after `level` rounds of pairwise reduction.
  function automatic int unsigned red_entries(input int unsigned nl, input int unsigned level);
    int unsigned n;
    n = nl;
    for (int unsigned i = 0; i < level; i++) n = (n + 1) / 2;
    return n;
  endfunction

endpackage

// File: rtl/red_tree_stage.sv
// One adder-tree level: extends each entry by one bit, adds adjacent pairs and registers
// the sums together with valid, lane mode and tag.
module red_tree_stage
  import red_pkg::*;
#(
  parameter int unsigned N_IN  = 4,
  parameter int unsigned W_IN  = 8,
  parameter int unsigned TAG_W = 4
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      flush,
  input  logic                                      en,
  input  logic                                      in_valid,
  input  logic                                      in_signed,
  input  logic [TAG_W-1:0]                          in_tag,
  input  logic [N_IN*W_IN-1:0]                      in_data,
  output logic                                      out_valid,
  output logic                                      out_signed,
  output logic [TAG_W-1:0]                          out_tag,
  output logic [((N_IN+1)/2)*(W_IN+1)-1:0]          out_data
);

  localparam int unsigned N_OUT = (N_IN + 1) / 2;
  localparam int unsigned W_OUT = W_IN + 1;
  localparam int unsigned PAD_W = 2 * N_OUT * W_IN;

  logic [PAD_W-1:0]       padded;
  logic [N_OUT*W_OUT-1:0] sum_next;

  function automatic logic [W_OUT-1:0] ext(input logic [W_IN-1:0] x, input logic s);
    return (s == RED_SIGNED) ? W_OUT'(signed'(x)) : W_OUT'(x);
  endfunction

  // An odd trailing entry meets a zero pad, so it passes through extended.
  always_comb begin
    padded   = PAD_W'(in_data);
    sum_next = '0;
    for (int unsigned i = 0; i < N_OUT; i++) begin
      sum_next[i*W_OUT +: W_OUT] = ext(padded[(2*i)*W_IN +: W_IN], in_signed)
                                 + ext(padded[(2*i+1)*W_IN +: W_IN], in_signed);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_signed <= 1'b0;
      out_tag    <= '0;
      out_data   <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (en) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_signed <= in_signed;
        out_tag    <= in_tag;
        out_data   <= sum_next;
      end
    end
  end

endmodule

// File: rtl/red_tree_pipe.sv
// Pipelined RED datapath: sums all LANE_W-bit lanes of A and B through a registered adder
// tree with valid/ready flow control, flush and a tag passthrough.
module red_tree_pipe
  import red_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned LANE_W = 8,
  parameter int unsigned TAG_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic              in_signed,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [TAG_W-1:0]  out_tag
);

  localparam int unsigned NL     = 2 * DATA_W / LANE_W;
  localparam int unsigned LEVELS = red_levels(DATA_W, LANE_W);
  localparam int unsigned SUM_W  = red_sum_w(DATA_W, LANE_W);

  if ((SUM_W > DATA_W) || ((DATA_W % LANE_W) != 0)) begin : g_param_check
    $error("red_tree_pipe: DATA_W must be a multiple of LANE_W and hold LANE_W+clog2(NL) bits");
  end

  logic [LEVELS-1:0] v;
  logic [LEVELS-1:0] en;
  logic [SUM_W-1:0]  sum_last;
  logic              sgn_last;

  for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
    localparam int unsigned N_IN  = red_entries(NL, k);
    localparam int unsigned W_IN  = LANE_W + k;
    localparam int unsigned N_OUT = red_entries(NL, k + 1);

    logic [N_IN*W_IN-1:0]       din;
    logic                       sin;
    logic [TAG_W-1:0]           tin;
    logic                       vin;
    logic [N_OUT*(W_IN+1)-1:0]  data;
    logic                       sgn;
    logic [TAG_W-1:0]           tag;

    if (k == 0) begin : g_src
      assign din = {in_b, in_a};
      assign vin = in_valid;
      assign sin = in_signed;
      assign tin = in_tag;
    end else begin : g_src
      assign din = g_lvl[k-1].data;
      assign vin = v[k-1];
      assign sin = g_lvl[k-1].sgn;
      assign tin = g_lvl[k-1].tag;
    end

    // Unrolled form of en[k] = !v[k] | en[k+1]: advance if any stage from here down is
    // empty or the consumer takes the result.
    assign en[k] = out_ready | ~(&v[LEVELS-1:k]);

    red_tree_stage #(
      .N_IN (N_IN),
      .W_IN (W_IN),
      .TAG_W(TAG_W)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .en        (en[k]),
      .in_valid  (vin),
      .in_signed (sin),
      .in_tag    (tin),
      .in_data   (din),
      .out_valid (v[k]),
      .out_signed(sgn),
      .out_tag   (tag),
      .out_data  (data)
    );

    if (k == LEVELS - 1) begin : g_out
      assign sum_last = data;
      assign sgn_last = sgn;
      assign out_tag  = tag;
    end
  end

  assign in_ready  = en[0];
  assign out_valid = v[LEVELS-1];

  always_comb begin
    out_data = (sgn_last == RED_SIGNED) ? DATA_W'(signed'(sum_last)) : DATA_W'(sum_last);
  end

endmodule

// File: tb/tb_red_tree_pipe.sv
// Scoreboarded bench for red_tree_pipe (default config) plus a LANE_W=4 instance.
module tb_red_tree_pipe;
  import red_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid, in_ready, in_signed;
  logic [15:0] in_a, in_b;
  logic [3:0]  in_tag;
  logic        out_valid, out_ready;
  logic [15:0] out_data;
  logic [3:0]  out_tag;

  logic        v4_in, r4_in, s4, f4, v4_out, r4_out;
  logic [15:0] a4, b4, d4;
  logic [3:0]  t4_in, t4_out;

  always #5 clk = ~clk;

  red_tree_pipe dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_signed(in_signed), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag)
  );

  red_tree_pipe #(.DATA_W(16), .LANE_W(4), .TAG_W(4)) dut4 (
    .clk(clk), .rst(rst), .flush(f4),
    .in_valid(v4_in), .in_ready(r4_in), .in_a(a4), .in_b(b4),
    .in_signed(s4), .in_tag(t4_in),
    .out_valid(v4_out), .out_ready(r4_out), .out_data(d4), .out_tag(t4_out)
  );

  typedef struct packed {
    logic [15:0] d;
    logic [3:0]  t;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  function automatic logic [15:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic sg, input int unsigned lw);
    logic [31:0] cat;
    int          sum;
    int unsigned lane;
    cat = {b, a};
    sum = 0;
    for (int unsigned i = 0; i < 32 / lw; i++) begin
      lane = (cat >> (i * lw)) & ((32'd1 << lw) - 32'd1);
      if (sg && lane >= (32'd1 << (lw - 1))) sum += int'(lane) - (1 << lw);
      else sum += int'(lane);
    end
    return 16'(sum);
  endfunction

  // Scoreboard monitor: sampled on the falling edge, i.e. what the next rising edge commits.
  logic        stalled = 1'b0;
  logic [15:0] held_d;
  logic [3:0]  held_t;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sb.delete();
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== held_d || out_tag !== held_t) begin
          errors++;
          $display("FAIL hold_stable: got v=%b data=%h tag=%h, required v=1 data=%h tag=%h",
                   out_valid, out_data, out_tag, held_d, held_t);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got data=%h tag=%h, required no output", out_data, out_tag);
        end else begin
          e = sb.pop_front();
          if (out_data !== e.d || out_tag !== e.t) begin
            errors++;
            $display("FAIL sb_result: got data=%h tag=%h, required data=%h tag=%h",
                     out_data, out_tag, e.d, e.t);
          end
        end
      end
      stalled = out_valid && !out_ready && !flush;
      held_d  = out_data;
      held_t  = out_tag;
      if (flush) sb.delete();
      else if (in_valid && in_ready) sb.push_back('{d: model(in_a, in_b, in_signed, 8), t: in_tag});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic s, input logic [3:0] t);
    in_valid  = 1'b1;
    in_a      = a;
    in_b      = b;
    in_signed = s;
    in_tag    = t;
  endtask

  task automatic test_reset();
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
    checks++;
    if (out_data !== 16'h0000) begin errors++; $display("FAIL reset_out_data: got %h, required 0000", out_data); end
    checks++;
    if (out_tag !== 4'h0) begin errors++; $display("FAIL reset_out_tag: got %h, required 0", out_tag); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
    checks++;
    if (v4_out !== 1'b0) begin errors++; $display("FAIL reset_lane4_valid: got %b, required 0", v4_out); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [15:0] va[4];
    logic [15:0] vb[4];
    logic        vs[4];
    logic [15:0] vexp[4];
    va   = '{16'hFFFF, 16'hFFFF, 16'h7F7F, 16'h7F7F};
    vb   = '{16'hFFFF, 16'hFFFF, 16'h8080, 16'h8080};
    vs   = '{1'b0, 1'b1, 1'b1, 1'b0};
    vexp = '{16'h03FC, 16'hFFFC, 16'hFFFE, 16'h01FE};
    for (int unsigned i = 0; i < 4; i++) begin
      tick();
      drive(va[i], vb[i], vs[i], 4'(i + 8));
      tick();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early[%0d]: got out_valid=%b, required 0", i, out_valid); end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== vexp[i] || out_tag !== 4'(i + 8)) begin
        errors++;
        $display("FAIL basic_result[%0d]: got v=%b data=%h tag=%h, required v=1 data=%h tag=%h",
                 i, out_valid, out_data, out_tag, vexp[i], 4'(i + 8));
      end
    end
  endtask

  task automatic test_back_to_back();
    tick();
    for (int unsigned c = 0; c < 6; c++) begin
      if (c < 4) drive(16'($urandom), 16'($urandom), 1'($urandom), 4'(c + 1));
      else in_valid = 1'b0;
      if (c >= 2) begin
        checks++;
        if (out_valid !== 1'b1 || out_tag !== 4'(c - 1)) begin
          errors++;
          $display("FAIL b2b_order[%0d]: got v=%b tag=%h, required v=1 tag=%h", c, out_valid, out_tag, 4'(c - 1));
        end
      end
      tick();
    end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_tail: got out_valid=%b, required 0", out_valid); end
  endtask

  task automatic test_backpressure();
    logic [3:0] t;
    logic       acc;
    int unsigned wait_cnt;
    tick();
    out_ready = 1'b0;
    t = 4'd1;
    drive(16'($urandom), 16'($urandom), 1'($urandom), t);
    for (int unsigned c = 0; c < 12; c++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (c == 1) begin
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
          errors++;
          $display("FAIL bp_full: got in_ready=%b out_valid=%b, required in_ready=0 out_valid=1", in_ready, out_valid);
        end
      end
      if (c == 3) out_ready = 1'b1;
      if (acc) begin
        t++;
        if (t <= 4'd6) drive(16'($urandom), 16'($urandom), 1'($urandom), t);
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    wait_cnt = 0;
    while (sb.size() != 0 && wait_cnt < 20) begin
      tick();
      wait_cnt++;
    end
    checks++;
    if (sb.size() != 0 || t != 4'd7) begin
      errors++;
      $display("FAIL bp_drain: got pending=%0d last_tag=%0d, required pending=0 last_tag=7", sb.size(), t);
    end
  endtask

  task automatic test_flush();
    tick();
    out_ready = 1'b0;
    drive(16'h1234, 16'h5678, 1'b0, 4'd9);
    tick();
    drive(16'h1111, 16'h2222, 1'b1, 4'd10);
    tick();
    drive(16'h3333, 16'h4444, 1'b0, 4'd11);
    flush = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_clear: got out_valid=%b in_ready=%b, required 0 and 1", out_valid, in_ready);
    end
    drive(16'h00FF, 16'h0102, 1'b0, 4'd12);
    tick();
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_tag !== 4'd12 || out_data !== 16'h0102) begin
      errors++;
      $display("FAIL flush_after: got v=%b data=%h tag=%h, required v=1 data=0102 tag=c", out_valid, out_data, out_tag);
    end
    tick();
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_ghost: got out_valid=%b, required 0", out_valid); end
  endtask

  task automatic test_async_reset();
    tick();
    out_ready = 1'b1;
    drive(16'hABCD, 16'h1357, 1'b1, 4'd1);
    tick();
    drive(16'hFFFF, 16'h0001, 1'b0, 4'd2);
    tick();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 16'h0000 || out_tag !== 4'h0) begin
      errors++;
      $display("FAIL async_rst_out: got v=%b data=%h tag=%h, required 0 0000 0", out_valid, out_data, out_tag);
    end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL async_rst_ready: got %b, required 1", in_ready); end
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL async_rst_drop: got out_valid=%b, required 0", out_valid); end
  endtask

  task automatic test_lane4();
    logic [15:0] exp4[2];
    logic        sg4[2];
    exp4 = '{16'hFFC0, 16'h0040};
    sg4  = '{1'b1, 1'b0};
    for (int unsigned i = 0; i < 2; i++) begin
      tick();
      v4_in = 1'b1; a4 = 16'h8888; b4 = 16'h8888; s4 = sg4[i]; t4_in = 4'(i + 5);
      tick();
      v4_in = 1'b0;
      tick();
      checks++;
      if (v4_out !== 1'b0) begin errors++; $display("FAIL lane4_early[%0d]: got out_valid=%b, required 0", i, v4_out); end
      tick();
      checks++;
      if (v4_out !== 1'b1 || d4 !== exp4[i] || t4_out !== 4'(i + 5)) begin
        errors++;
        $display("FAIL lane4_result[%0d]: got v=%b data=%h tag=%h, required v=1 data=%h tag=%h",
                 i, v4_out, d4, t4_out, exp4[i], 4'(i + 5));
      end
      checks++;
      if (d4 !== model(16'h8888, 16'h8888, sg4[i], 4)) begin
        errors++;
        $display("FAIL lane4_model[%0d]: got %h, required %h", i, d4, model(16'h8888, 16'h8888, sg4[i], 4));
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_signed = 1'b0; in_tag = '0; out_ready = 1'b1;
    v4_in = 1'b0; a4 = '0; b4 = '0; s4 = 1'b0; t4_in = '0; f4 = 1'b0; r4_out = 1'b1;
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_lane4();
    tick();
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/red_tree_pipe.md
Name: red_tree_pipe

Overview:
- Pipelined, parametrised successor to the single-cycle RED datapath used by the EX stage.
- Splits operands A and B into LANE_W-bit lanes and sums all 2*DATA_W/LANE_W lanes through a registered adder tree, one register stage per tree level.
- Per-transaction signed/unsigned lane mode, valid/ready handshakes with per-stage bubble collapsing, a synchronous flush for pipeline squash, and a destination-tag passthrough for writeback.

Parameters:
- DATA_W, 16: operand and result width.
- LANE_W, 8: lane width. DATA_W must be a multiple of LANE_W.
- TAG_W, 4: width of the tag carried alongside each transaction (destination register id).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous squash of all in-flight transactions.
- in_valid  in  1  an operand pair is presented.
- in_ready  out  1  the block accepts the operand pair this cycle.
- in_a  in  DATA_W  operand A.
- in_b  in  DATA_W  operand B.
- in_signed  in  1  1 = lanes are two's complement; 0 = lanes are unsigned.
- in_tag  in  TAG_W  tag, returned unchanged with the result.
- out_valid  out  1  a result is present.
- out_ready  in  1  the consumer takes the result this cycle.
- out_data  out  DATA_W  reduced sum, extended to DATA_W.
- out_tag  out  TAG_W  tag of the result.

Behaviour:
- Derived constants:
  - NL = 2*DATA_W/LANE_W lanes.
  - LEVELS = clog2(NL) register stages.
  - SUM_W = LANE_W + LEVELS (exact sum width).
  - Elaboration error if SUM_W > DATA_W or if DATA_W % LANE_W != 0.
- Lane order: lanes 0..NL/2-1 are in_a from the LSB upward; lanes NL/2..NL-1 are in_b from the LSB upward.
- Lane extension: each lane is sign-extended (in_signed=1) or zero-extended (in_signed=0) to SUM_W before the first add.
- Tree structure:
  - Stage k adds adjacent pairs from stage k-1 and registers them, together with valid, signed and tag.
  - If NL is not a power of two, unpaired entries pass through with extension.
- Result: the final SUM_W-bit sum is sign-extended (signed) or zero-extended (unsigned) to DATA_W. The sum is exact; overflow is impossible by construction.
- Handshake and stall:
  - Per-stage advance enable: en[k] = !v[k] | en[k+1]; at the last stage, en[LAST] = !v[LAST] | out_ready.
  - in_ready = en[0]. A combinational ready chain is permitted.
  - Transfer occurs when valid & ready are both high. A stage with en=0 holds its data and valid.
  - Bubbles collapse: an empty stage accepts even when a downstream stage is stalled.
- Latency: out_valid rises LEVELS cycles after the accepting edge when there is no backpressure. Throughput is 1 per cycle. Default configuration: LEVELS=2.
- out_data and out_tag are the last-stage registers. They are stable while out_valid=1 and out_ready=0.
- flush:
  - On the edge where flush=1, all stage valid bits clear.
  - An in_valid presented in the same cycle is dropped, regardless of in_ready.
  - Data registers need not clear.
- Reset: asynchronous. All valid bits = 0; out_valid = 0; out_data = 0; out_tag = 0. in_ready = 1 immediately after reset. Reset mid-operation discards all in-flight work.
- Simultaneous events: flush takes priority over in_valid and out_ready. An out_ready handshake coincident with flush is still a completed transfer for the consumer.

Decomposition:
- Shared package (red_pkg): a clog2 helper function, the SUM_W/LEVELS derivation functions, and a lane-mode constant (RED_UNSIGNED=0, RED_SIGNED=1).
- One natural sub-module, red_tree_stage. It is parametrised by input entry count and entry width, owns one tree level's pairwise adders plus its valid/signed/tag register, and is instantiated LEVELS times in a generate loop.
- Adders use the behavioural +. Top level holds only lane slicing, final extension and the enable chain.

Test Plan:
- Default params, in_a=16'hFFFF, in_b=16'hFFFF, unsigned -> out_data=16'h03FC (1020) after exactly 2 cycles; out_tag echoed.
- Same operands, signed -> out_data=16'hFFFC (-4). in_a=16'h7F7F, in_b=16'h8080, signed -> 16'hFFFE (-2); unsigned -> 16'h01FE (510).
- Back-to-back: 4 consecutive transactions with out_ready=1 -> 4 results on consecutive cycles, in order, tags 1..4.
- Backpressure: out_ready=0 for 4 cycles while feeding continuously -> in_ready drops once both stages hold valid data; out_data/out_tag are stable; no loss or duplication after out_ready returns.
- flush with 2 transactions in flight plus in_valid=1 in the same cycle -> out_valid=0 next cycle; none of the three ever emerge; a new transaction on the following cycle completes normally.
- Assert rst asynchronously mid-stream (between clock edges) -> out_valid=0, out_data=0 immediately; in_ready=1. Also run with LANE_W=4 (NL=8, LEVELS=3): signed all-0x8 lanes -> 16'hFFC0 (-64) after 3 cycles.
